// File: rtl/splash_scheduler.sv
// Splash sprite pool: spawn/evict + per-frame lifetime, shadowed per frame; pixel valid ROM_LATENCY cycles after rom_addr.
// No backpressure: spawn_ready is high whenever out of reset, and a full pool evicts the slot with the least life left.
module splash_scheduler #(
   parameter int          NSLOTS          = 4,
   parameter int          SPRITE_W        = 50,
   parameter int          SPRITE_H        = 50,
   parameter int          ADDR_W          = 13,
   parameter int          LIFETIME_FRAMES = 30,
   parameter int          ROM_LATENCY     = 2,
   parameter logic [11:0] TRANSPARENT     = 12'h000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_tick,
   input  logic              spawn_valid,
   output logic              spawn_ready,
   input  logic [9:0]        spawn_x,
   input  logic [8:0]        spawn_y,
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_color,
   output logic              pix_valid,
   output logic [11:0]       pix_color,
   output logic [NSLOTS-1:0] active_mask,
   output logic [7:0]        drop_count
);
   localparam int LIFE_W = $clog2(LIFETIME_FRAMES + 1);
   localparam int SLOT_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

   logic [9:0]        sx       [NSLOTS];
   logic [8:0]        sy       [NSLOTS];
   logic [LIFE_W-1:0] life     [NSLOTS];
   logic [LIFE_W-1:0] lifeNext [NSLOTS];
   logic [9:0]        shSx     [NSLOTS];
   logic [8:0]        shSy     [NSLOTS];
   logic [NSLOTS-1:0] shActive;

   logic              doSpawn;
   logic              freeFound;
   logic [SLOT_W-1:0] freeIdx;
   logic [SLOT_W-1:0] minIdx;
   logic [SLOT_W-1:0] target;
   logic [LIFE_W-1:0] minLife;

   logic [NSLOTS-1:0]      hitVec;
   logic [ADDR_W-1:0]      addrVec [NSLOTS];
   logic                   hit;
   logic [ROM_LATENCY-1:0] hitPipe;

   assign doSpawn = spawn_valid && spawn_ready;

   // Strict less-than keeps the lowest index among equal-life candidates.
   always_comb begin
      freeFound = 1'b0;
      freeIdx   = '0;
      minIdx    = '0;
      minLife   = life[0];
      for (int i = 0; i < NSLOTS; i++) begin
         if (!freeFound && life[i] == '0) begin
            freeFound = 1'b1;
            freeIdx   = SLOT_W'(i);
         end
         if (life[i] < minLife) begin
            minLife = life[i];
            minIdx  = SLOT_W'(i);
         end
      end
      target = freeFound ? freeIdx : minIdx;
   end

   always_comb begin
      for (int i = 0; i < NSLOTS; i++) begin
         lifeNext[i] = life[i];
         if (frame_tick && life[i] != '0)
            lifeNext[i] = life[i] - LIFE_W'(1);
         if (doSpawn && target == SLOT_W'(i))
            lifeNext[i] = LIFE_W'(LIFETIME_FRAMES);
      end
   end

   // Bounds are widened one bit so sprites hanging off the screen edge clip instead of wrapping.
   for (genvar g = 0; g < NSLOTS; g++) begin : gSlot
      logic [10:0] xLo, xHi;
      logic [9:0]  yLo, yHi;
      assign xLo = {1'b0, shSx[g]};
      assign xHi = xLo + 11'(SPRITE_W);
      assign yLo = {1'b0, shSy[g]};
      assign yHi = yLo + 10'(SPRITE_H);
      assign hitVec[g] = shActive[g] && ({1'b0, x} >= xLo) && ({1'b0, x} < xHi)
                         && ({1'b0, y} >= yLo) && ({1'b0, y} < yHi);
      assign addrVec[g] = ADDR_W'(x - shSx[g]) + ADDR_W'(SPRITE_W) * ADDR_W'(y - shSy[g]);
   end

   always_comb begin
      hit      = 1'b0;
      rom_addr = '0;
      for (int i = NSLOTS - 1; i >= 0; i--) begin
         if (hitVec[i]) begin
            hit      = 1'b1;
            rom_addr = addrVec[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spawn_ready <= 1'b0;
         active_mask <= '0;
         drop_count  <= '0;
         shActive    <= '0;
         hitPipe     <= '0;
         for (int i = 0; i < NSLOTS; i++) begin
            sx[i]   <= '0;
            sy[i]   <= '0;
            life[i] <= '0;
            shSx[i] <= '0;
            shSy[i] <= '0;
         end
      end else begin
         spawn_ready <= 1'b1;
         for (int i = 0; i < NSLOTS; i++) begin
            life[i]        <= lifeNext[i];
            active_mask[i] <= (lifeNext[i] != '0);
         end
         if (doSpawn) begin
            sx[target] <= spawn_x;
            sy[target] <= spawn_y;
            if (!freeFound && drop_count != 8'hFF)
               drop_count <= drop_count + 8'd1;
         end
         // Snapshot takes pre-update state, so a same-cycle spawn first shows next frame.
         if (frame_tick) begin
            for (int i = 0; i < NSLOTS; i++) begin
               shSx[i]     <= sx[i];
               shSy[i]     <= sy[i];
               shActive[i] <= (life[i] != '0);
            end
         end
         hitPipe[0] <= hit;
         for (int i = 1; i < ROM_LATENCY; i++)
            hitPipe[i] <= hitPipe[i-1];
      end
   end

   assign pix_valid = hitPipe[ROM_LATENCY-1] && (rom_color != TRANSPARENT);
   assign pix_color = pix_valid ? rom_color : 12'h000;

endmodule

// File: tb/tb_splash_scheduler.sv
// Bench for splash_scheduler: directed spawns/ticks/pixels, expectations queued with a due cycle and checked by a monitor.
module tb_splash_scheduler;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        spawn_valid = 1'b0;
   logic        spawn_ready;
   logic [9:0]  spawn_x = '0;
   logic [8:0]  spawn_y = '0;
   logic [9:0]  x = '0;
   logic [8:0]  y = '0;
   logic [12:0] rom_addr;
   logic [11:0] rom_color = '0;
   logic        pix_valid;
   logic [11:0] pix_color;
   logic [3:0]  active_mask;
   logic [7:0]  drop_count;

   splash_scheduler dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .x(x), .y(y),
      .rom_addr(rom_addr), .rom_color(rom_color),
      .pix_valid(pix_valid), .pix_color(pix_color),
      .active_mask(active_mask), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Stand-in sprite ROM: address 1 is transparent, everything else is a distinct opaque colour.
   function automatic logic [11:0] romFn(input logic [12:0] a);
      if (a == 13'd1) return 12'h000;
      return 12'hF80 ^ a[11:0];
   endfunction

   logic [11:0] romStage = '0;
   always @(posedge clk) begin
      romStage  <= romFn(rom_addr);
      rom_color <= romStage;
   end

   typedef struct {
      int due;
      int kind;
      int exp;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int dutVal(input int kind);
      case (kind)
         0: return int'(rom_addr);
         1: return int'(pix_valid);
         2: return int'(pix_color);
         3: return int'(active_mask);
         4: return int'(drop_count);
         default: return int'(spawn_ready);
      endcase
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         0: return "rom_addr";
         1: return "pix_valid";
         2: return "pix_color";
         3: return "active_mask";
         4: return "drop_count";
         default: return "spawn_ready";
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            int act;
            act = dutVal(sb[i].kind);
            checks++;
            if (act != sb[i].exp) begin
               failures++;
               $display("FAIL %s due_cycle=%0d got=0x%0h expected=0x%0h",
                        kname(sb[i].kind), sb[i].due, act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expectVal(input int kind, input int exp, input int delay = 0);
      chk_t c;
      c.due  = cyc + delay;
      c.kind = kind;
      c.exp  = exp;
      sb.push_back(c);
   endtask

   task automatic pixel(input int px, input int py, input bit isHit, input int addr);
      bit          pv;
      logic [11:0] col;
      x   = 10'(px);
      y   = 9'(py);
      col = romFn(13'(addr));
      pv  = isHit && (col != 12'h000);
      expectVal(0, isHit ? addr : 0);
      expectVal(1, int'(pv), L);
      expectVal(2, pv ? int'(col) : 0, L);
      step();
   endtask

   task automatic spawn(input int px, input int py, input bit withTick = 1'b0);
      spawn_valid = 1'b1;
      spawn_x     = 10'(px);
      spawn_y     = 9'(py);
      frame_tick  = withTick;
      step();
      spawn_valid = 1'b0;
      frame_tick  = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic expectResetState();
      for (int k = 0; k <= 5; k++) expectVal(k, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      expectResetState();
      step();
      reset_n = 1'b1;
      step();
      expectVal(5, 1);

      // Single splash: invisible until the next tick, then addressed from its corner
      spawn(100, 200);
      expectVal(3, 1);
      expectVal(4, 0);
      pixel(100, 200, 0, 0);
      tick();
      pixel(100, 200, 1, 0);
      pixel(149, 249, 1, 2499);
      pixel(150, 249, 0, 0);
      pixel(101, 200, 1, 1);
      pixel(120, 230, 1, 1520);
      pixel(100, 250, 0, 0);

      // Lifetime: visible through tick 30, gone after tick 31
      repeat (28) tick();
      expectVal(3, 1);
      tick();
      expectVal(3, 0);
      pixel(100, 200, 1, 0);
      tick();
      pixel(100, 200, 0, 0);

      // Spawn coinciding with a tick
      spawn(300, 100, 1'b1);
      expectVal(3, 1);
      pixel(300, 100, 0, 0);
      tick();
      pixel(300, 100, 1, 0);
      pixel(349, 149, 1, 2499);
      expectVal(4, 0);
      repeat (29) tick();
      pixel(300, 100, 1, 0);
      tick();
      pixel(300, 100, 0, 0);
      repeat (3) step();

      // Eviction: fill, then evict lowest life with lowest-index tie break
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      spawn(0, 0);
      spawn(200, 0);
      spawn(400, 0);
      spawn(0, 300);
      expectVal(3, 15);
      expectVal(4, 0);
      tick();
      spawn(100, 100);
      expectVal(4, 1);
      tick();
      spawn(120, 110);
      expectVal(4, 2);
      expectVal(3, 15);
      tick();
      pixel(130, 120, 1, 1030);
      pixel(169, 159, 1, 2499);
      pixel(200, 0, 0, 0);
      pixel(400, 0, 1, 0);
      pixel(0, 300, 1, 0);
      pixel(5, 5, 0, 0);

      // Screen-edge sprite evicts slot 2 (life tie with slot 3)
      spawn(620, 460);
      expectVal(4, 3);
      tick();
      pixel(400, 0, 0, 0);
      pixel(0, 300, 1, 0);
      pixel(639, 479, 1, 969);
      repeat (2) step();

      // Mid-frame async reset while a hit is streaming
      reset_n = 1'b0;
      expectResetState();
      step();
      reset_n = 1'b1;
      step();

      for (int k = 0; k < 20 && sb.size() > 0; k++) step();
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
